// File: rtl/rv32_mod_bus_arbiter_if.sv
// ============================================================================
// rv32_mod_bus_arbiter_if : fetch, LSU and downstream memory bus bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface rv32_mod_bus_arbiter_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_ack;
  logic        instr_err;
  logic [31:0] instr_rdata;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic        data_err;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        mem_err;
  logic [31:0] mem_rdata;

  logic [1:0]  grant;
  logic        timeout;

  // Arbiter side
  modport slave (
    input  instr_req, instr_addr,
    output instr_ack, instr_err, instr_rdata,
    input  data_req, data_wr, data_be, data_addr, data_wdata,
    output data_ack, data_err, data_rdata,
    output mem_req, mem_wr, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_err, mem_rdata,
    output grant, timeout
  );

  // Requester / memory side
  modport master (
    output instr_req, instr_addr,
    input  instr_ack, instr_err, instr_rdata,
    output data_req, data_wr, data_be, data_addr, data_wdata,
    input  data_ack, data_err, data_rdata,
    input  mem_req, mem_wr, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_err, mem_rdata,
    input  grant, timeout
  );
endinterface

`default_nettype wire

// File: rtl/rv32_mod_bus_arbiter.sv
// ============================================================================
// rv32_mod_bus_arbiter : fetch/LSU round-robin arbiter with bus timeout
// Revision: 1.0
// ============================================================================
`default_nettype none

module rv32_mod_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  rv32_mod_bus_arbiter_if.slave bus
);

  localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_tmo_last =
    (TIMEOUT_CYCLES > 0) ? c_cnt_w'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_last_d;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_mem_req;
  logic                 r_mem_wr;
  logic [3:0]           r_mem_be;
  logic [31:0]          r_mem_addr;
  logic [31:0]          r_mem_wdata;
  logic                 w_win_i;
  logic                 w_win_d;
  logic                 w_resp;
  logic                 w_tmo;
  logic                 w_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_win_i         = 1'b0;
    w_win_d         = 1'b0;
    w_tmo           = 1'b0;
    w_done          = 1'b0;
    w_resp          = bus.mem_ack | bus.mem_err;
    bus.instr_ack   = 1'b0;
    bus.instr_err   = 1'b0;
    bus.instr_rdata = 32'h0;
    bus.data_ack    = 1'b0;
    bus.data_err    = 1'b0;
    bus.data_rdata  = 32'h0;
    bus.grant       = 2'b00;
    bus.timeout     = 1'b0;

    case (r_state)
      IDLE: begin
        // On a tie the requester that did not win last time goes first
        if (bus.instr_req && bus.data_req) begin
          w_win_i = r_last_d;
          w_win_d = ~r_last_d;
        end else begin
          w_win_i = bus.instr_req;
          w_win_d = bus.data_req;
        end
        if (w_win_i) begin
          w_state_nxt = GNT_I;
        end else if (w_win_d) begin
          w_state_nxt = GNT_D;
        end
      end

      GNT_I, GNT_D: begin
        w_tmo       = (TIMEOUT_CYCLES > 0) && !w_resp && (r_cnt == c_tmo_last);
        w_done      = w_resp | w_tmo;
        bus.timeout = w_tmo;
        if (r_state == GNT_I) begin
          bus.grant       = 2'b01;
          bus.instr_ack   = bus.mem_ack & ~bus.mem_err;
          bus.instr_err   = bus.mem_err | w_tmo;
          bus.instr_rdata = bus.mem_rdata;
        end else begin
          bus.grant       = 2'b10;
          bus.data_ack    = bus.mem_ack & ~bus.mem_err;
          bus.data_err    = bus.mem_err | w_tmo;
          bus.data_rdata  = bus.mem_rdata;
        end
        if (w_done) begin
          w_state_nxt = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // Downstream request is captured at the grant edge and frozen until completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_req   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_be    <= 4'h0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_cnt       <= '0;
      r_last_d    <= 1'b1;
    end else if (w_win_i) begin
      r_mem_req   <= 1'b1;
      r_mem_wr    <= 1'b0;
      r_mem_be    <= 4'hF;
      r_mem_addr  <= bus.instr_addr;
      r_mem_wdata <= 32'h0;
      r_cnt       <= '0;
      r_last_d    <= 1'b0;
    end else if (w_win_d) begin
      r_mem_req   <= 1'b1;
      r_mem_wr    <= bus.data_wr;
      r_mem_be    <= bus.data_be;
      r_mem_addr  <= bus.data_addr;
      r_mem_wdata <= bus.data_wdata;
      r_cnt       <= '0;
      r_last_d    <= 1'b1;
    end else if (w_done) begin
      r_mem_req   <= 1'b0;
    end else if (r_mem_req) begin
      r_cnt       <= r_cnt + 1'b1;
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_rv32_mod_bus_arbiter.sv
// ============================================================================
// tb_rv32_mod_bus_arbiter : scoreboard bench for the fetch/LSU bus arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rv32_mod_bus_arbiter;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   model_last_d = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv32_mod_bus_arbiter_if bus ();

  rv32_mod_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          is_d;
    bit          err;
    bit          tmo;
    logic [31:0] rdata;
    logic [31:0] addr;
    bit          wr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return 160'({bus.mem_req, bus.mem_wr, bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.grant,
                 bus.instr_ack, bus.instr_err, bus.instr_rdata,
                 bus.data_ack, bus.data_err, bus.data_rdata, bus.timeout});
  endfunction

  function automatic int pick_mode();
    int v;
    v = int'($urandom_range(9, 0));
    return (v < 6) ? 0 : (v < 8) ? 1 : 2;
  endfunction

  // Monitor: every response pulse must match the oldest expected transaction
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.instr_ack || bus.instr_err || bus.data_ack || bus.data_err) begin
        if (sb.size() == 0) begin
          check("unexpected_resp",
                160'({bus.instr_ack, bus.instr_err, bus.data_ack, bus.data_err}), 160'(0));
        end else begin
          mon_e = sb.pop_front();
          check("resp_port", 160'({bus.data_ack | bus.data_err, bus.instr_ack | bus.instr_err}),
                160'(mon_e.is_d ? 2'b10 : 2'b01));
          check("resp_ack_err",
                160'(mon_e.is_d ? {bus.data_ack, bus.data_err} : {bus.instr_ack, bus.instr_err}),
                160'({~mon_e.err, mon_e.err}));
          check("resp_timeout", 160'(bus.timeout), 160'(mon_e.tmo));
          check("resp_cycle", 160'(cyc), 160'(mon_e.cyc));
          check("resp_grant", 160'(bus.grant), 160'(mon_e.is_d ? 2'b10 : 2'b01));
          check("nonowner_rdata", 160'(mon_e.is_d ? bus.instr_rdata : bus.data_rdata), 160'(0));
          if (!mon_e.err) begin
            check("owner_rdata", 160'(mon_e.is_d ? bus.data_rdata : bus.instr_rdata),
                  160'(mon_e.rdata));
          end
          check("latched_req", 160'({bus.mem_wr, bus.mem_be, bus.mem_addr, bus.mem_wdata}),
                160'({mon_e.wr, mon_e.be, mon_e.addr, mon_e.wdata}));
        end
      end else begin
        check("stray_timeout", 160'(bus.timeout), 160'(0));
      end
    end
  end

  // Called at cycle 1 of a granted transaction; returns in the idle cycle after it
  task automatic serve(input bit is_d, input int lat, input int mode, input logic [31:0] rdata,
                       input bit scramble, input bit stray);
    exp_t e;
    int   last;
    last    = (lat > TMO) ? TMO : lat;
    e.is_d  = is_d;
    e.tmo   = (lat > TMO);
    e.err   = e.tmo || (mode != 0);
    e.rdata = rdata;
    e.addr  = is_d ? bus.data_addr : bus.instr_addr;
    e.wr    = is_d ? bus.data_wr : 1'b0;
    e.be    = is_d ? bus.data_be : 4'hF;
    e.wdata = is_d ? bus.data_wdata : 32'h0;
    e.cyc   = cyc + last - 1;
    sb.push_back(e);
    model_last_d = is_d;
    check("mem_req_rise", 160'(bus.mem_req), 160'(1));
    check("grant_start", 160'(bus.grant), 160'(is_d ? 2'b10 : 2'b01));
    for (int k = 1; k <= last; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      bus.mem_ack   = 1'b0;
      bus.mem_err   = 1'b0;
      bus.mem_rdata = $urandom();
      if (scramble) begin
        if (is_d) begin
          bus.data_addr  = $urandom();
          bus.data_wdata = $urandom();
          bus.data_be    = 4'($urandom());
          bus.data_wr    = 1'($urandom());
        end else begin
          bus.instr_addr = $urandom();
        end
      end
      if (k == lat) begin
        bus.mem_rdata = rdata;
        bus.mem_ack   = (mode != 1);
        bus.mem_err   = (mode != 0);
      end
    end
    @(posedge clk);
    #1;
    bus.mem_ack   = stray;
    bus.mem_err   = 1'b0;
    bus.mem_rdata = $urandom();
    if (is_d) bus.data_req = 1'b0;
    else      bus.instr_req = 1'b0;
    check("idle_gap_req", 160'(bus.mem_req), 160'(0));
    check("idle_gap_grant", 160'(bus.grant), 160'(0));
  endtask

  task automatic round(input bit ri, input bit rd,
                       input int lat_i, input int mode_i, input logic [31:0] rdata_i,
                       input int lat_d, input int mode_d, input logic [31:0] rdata_d,
                       input bit scramble, input bit stray);
    bit first_d;
    bus.instr_req = ri;
    bus.data_req  = rd;
    first_d = (ri && rd) ? !model_last_d : rd;
    @(posedge clk);
    #1;
    if (first_d) serve(1'b1, lat_d, mode_d, rdata_d, scramble, stray);
    else         serve(1'b0, lat_i, mode_i, rdata_i, scramble, stray);
    if (ri && rd) begin
      @(posedge clk);
      #1;
      if (first_d) serve(1'b0, lat_i, mode_i, rdata_i, scramble, stray);
      else         serve(1'b1, lat_d, mode_d, rdata_d, scramble, stray);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.instr_req = 1'b0;  bus.instr_addr = 32'h0;
    bus.data_req  = 1'b0;  bus.data_wr = 1'b0; bus.data_be = 4'h0;
    bus.data_addr = 32'h0; bus.data_wdata = 32'h0;
    bus.mem_ack   = 1'b0;  bus.mem_err = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 160'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Ties from reset alternate I, D, I, D
    bus.instr_addr = 32'h0000_1000; bus.data_addr = 32'h0000_2000;
    bus.data_wr = 1'b0; bus.data_be = 4'hF; bus.data_wdata = 32'h0;
    round(1'b1, 1'b1, 1, 0, 32'h1111_1111, 1, 0, 32'h2222_2222, 1'b0, 1'b0);
    round(1'b1, 1'b1, 2, 0, 32'h3333_3333, 1, 0, 32'h4444_4444, 1'b0, 1'b0);

    // Fetch only, ack one cycle after mem_req
    bus.instr_addr = 32'h1000_0000;
    round(1'b1, 1'b0, 2, 0, 32'h0000_0013, 1, 0, 32'h0, 1'b0, 1'b0);

    // Store with requester inputs changing while waiting
    bus.data_addr = 32'h8000_0004; bus.data_be = 4'b0011;
    bus.data_wdata = 32'hDEAD_BEEF; bus.data_wr = 1'b1;
    round(1'b0, 1'b1, 1, 0, 32'h0, 3, 0, 32'h5555_5555, 1'b1, 1'b0);

    // Timeout on data, then a late ack in idle
    bus.data_addr = 32'h0000_0040; bus.data_wr = 1'b0; bus.data_be = 4'hF;
    round(1'b0, 1'b1, 1, 0, 32'h0, 6, 0, 32'h6666_6666, 1'b0, 1'b1);

    // ack and err together on fetch, then stray ack in idle
    bus.instr_addr = 32'h0000_0080;
    round(1'b1, 1'b0, 2, 2, 32'h7777_7777, 1, 0, 32'h0, 1'b0, 1'b1);

    for (int r = 0; r < 40; r++) begin
      int sel;
      sel = int'($urandom_range(2, 0));
      bus.instr_addr = $urandom();
      bus.data_addr  = $urandom();
      bus.data_wdata = $urandom();
      bus.data_be    = 4'($urandom());
      bus.data_wr    = 1'($urandom());
      round(sel != 1, sel != 0,
            int'($urandom_range(6, 1)), pick_mode(), $urandom(),
            int'($urandom_range(6, 1)), pick_mode(), $urandom(),
            1'($urandom()), 1'($urandom()));
    end

    // Reset in the middle of a fetch
    bus.mem_ack = 1'b0;
    bus.instr_addr = 32'h0000_0100;
    bus.instr_req = 1'b1;
    @(posedge clk);
    #1;
    check("pre_reset_req", 160'(bus.mem_req), 160'(1));
    reset = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    #1;
    check("reset_mid_txn", all_outs(), 160'(0));
    @(posedge clk);
    #1;
    check("reset_held", all_outs(), 160'(0));
    bus.mem_ack = 1'b0;
    bus.instr_req = 1'b0;
    sb.delete();
    model_last_d = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // After reset a tie goes to instr first
    bus.instr_addr = 32'h0000_0200; bus.data_addr = 32'h0000_0300;
    round(1'b1, 1'b1, 1, 0, 32'h8888_8888, 2, 0, 32'h9999_9999, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 160'(sb.size()), 160'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
